// File: rtl/an_sec_decoder_seq_if.sv
// Handshake bus of the AN-code SEC decoder: codeword in, decoded result out.
interface an_sec_decoder_seq_if #(
   parameter int W_BITS = 32,
   parameter int N_BITS = 25,
   parameter int P_BITS = 6
);
   logic              in_valid;
   logic              in_ready;
   logic [W_BITS-1:0] W;
   logic              out_valid;
   logic              out_ready;
   logic [N_BITS-1:0] N;
   logic              corrected;
   logic              uncorrectable;
   logic              ovf;
   logic [P_BITS-1:0] err_pos;
   logic              err_sign;

   modport master (
      output in_valid, W, out_ready,
      input  in_ready, out_valid, N, corrected, uncorrectable, ovf, err_pos, err_sign
   );

   modport slave (
      input  in_valid, W, out_ready,
      output in_ready, out_valid, N, corrected, uncorrectable, ovf, err_pos, err_sign
   );
endinterface

// File: rtl/an_sec_decoder_seq.sv
// Sequential single-error-correcting AN-code decoder. One bit-serial restoring
// divider is reused for the syndrome division and the corrected re-division;
// residues 2^k mod A are generated by doubling instead of a table.
module an_sec_decoder_seq #(
   parameter int A       = 67,
   parameter int W_BITS  = 32,
   parameter int A_BITS  = 7,
   parameter int N_BITS  = 25,
   parameter int K_RANGE = 33,
   parameter int P_BITS  = 6
) (
   input logic               clk,
   input logic               rst,
   an_sec_decoder_seq_if.slave bus
);
   localparam int CNT_BITS = (W_BITS > 1) ? $clog2(W_BITS) : 1;
   localparam logic [A_BITS:0]   A_X = (A_BITS+1)'(A);
   localparam logic [A_BITS-1:0] A_R = A_BITS'(A);

   typedef enum logic [2:0] {IDLE, DIV1, SEARCH, CHECK, DIV2, DONE} state_t;

   state_t              state_q, state_d;
   logic [W_BITS-1:0]   w_reg_q, w_reg_d;   // captured codeword, needed again in CHECK
   logic [W_BITS-1:0]   sh_q, sh_d;         // dividend shifts out MSB, quotient shifts in LSB
   logic [A_BITS-1:0]   rem_q, rem_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic [A_BITS-1:0]   p_q, p_d;           // 2^k mod A
   logic [P_BITS-1:0]   k_q, k_d;
   logic                sgn_q, sgn_d;
   logic [N_BITS-1:0]   n_q, n_d;
   logic                cor_q, cor_d;
   logic                unc_q, unc_d;
   logic                ovf_q, ovf_d;
   logic [P_BITS-1:0]   pos_q, pos_d;

   // One restoring-division step
   logic [A_BITS:0]     trial;
   logic                ge;
   logic [A_BITS-1:0]   rem_nx;
   logic [W_BITS-1:0]   sh_nx;
   logic                last;
   assign trial  = {rem_q, sh_q[W_BITS-1]};
   assign ge     = trial >= A_X;
   assign rem_nx = ge ? A_BITS'(trial - A_X) : A_BITS'(trial);
   assign sh_nx  = {sh_q[W_BITS-2:0], ge};
   assign last   = cnt_q == CNT_BITS'(W_BITS-1);

   // Residue search: compare against +2^k and -2^k, then double mod A
   logic [A_BITS:0]     p2;
   logic [A_BITS-1:0]   p_nx;
   logic                hit_pos, hit_neg;
   assign p2      = {p_q, 1'b0};
   assign p_nx    = (p2 >= A_X) ? A_BITS'(p2 - A_X) : A_BITS'(p2);
   assign hit_pos = rem_q == p_q;
   assign hit_neg = rem_q == (A_R - p_q);

   // Correction in W_BITS+2 bits so both underflow and overflow are visible
   logic [W_BITS+1:0]   pow, w_ext, w_new;
   logic                oob;
   assign pow   = {{(W_BITS+1){1'b0}}, 1'b1} << k_q;
   assign w_ext = {2'b00, w_reg_q};
   assign w_new = sgn_q ? (w_ext + pow) : (w_ext - pow);
   assign oob   = |w_new[W_BITS+1:W_BITS];

   logic [W_BITS-1:0]   qsel;
   logic                fin;

   // Next-state and datapath control
   always_comb begin
      state_d = state_q;
      w_reg_d = w_reg_q;
      sh_d    = sh_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      k_d     = k_q;
      sgn_d   = sgn_q;
      n_d     = n_q;
      cor_d   = cor_q;
      unc_d   = unc_q;
      ovf_d   = ovf_q;
      pos_d   = pos_q;
      qsel    = sh_q;
      fin     = 1'b0;
      case (state_q)
         IDLE: if (bus.in_valid) begin
            w_reg_d = bus.W;
            sh_d    = bus.W;
            rem_d   = '0;
            cnt_d   = '0;
            sgn_d   = 1'b0;
            state_d = DIV1;
         end
         DIV1: begin
            sh_d  = sh_nx;
            rem_d = rem_nx;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
               if (rem_nx == '0) begin
                  qsel    = sh_nx;
                  fin     = 1'b1;
                  cor_d   = 1'b0;
                  unc_d   = 1'b0;
                  pos_d   = '0;
                  state_d = DONE;
               end else begin
                  p_d     = A_BITS'(1);
                  k_d     = '0;
                  state_d = SEARCH;
               end
            end
         end
         SEARCH: begin
            if (hit_pos) begin
               sgn_d   = 1'b0;
               state_d = CHECK;
            end else if (hit_neg) begin
               sgn_d   = 1'b1;
               state_d = CHECK;
            end else if (k_q == P_BITS'(K_RANGE-1)) begin
               fin     = 1'b1;
               cor_d   = 1'b0;
               unc_d   = 1'b1;
               pos_d   = '0;
               state_d = DONE;
            end else begin
               p_d = p_nx;
               k_d = k_q + 1'b1;
            end
         end
         CHECK: begin
            if (oob) begin
               fin     = 1'b1;
               cor_d   = 1'b0;
               unc_d   = 1'b1;
               pos_d   = k_q;
               state_d = DONE;
            end else begin
               sh_d    = w_new[W_BITS-1:0];
               rem_d   = '0;
               cnt_d   = '0;
               state_d = DIV2;
            end
         end
         DIV2: begin
            sh_d  = sh_nx;
            rem_d = rem_nx;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
               qsel    = sh_nx;
               fin     = 1'b1;
               cor_d   = 1'b1;
               unc_d   = 1'b0;
               pos_d   = k_q;
               state_d = DONE;
            end
         end
         DONE: if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (fin) begin
         n_d   = N_BITS'(qsel);
         ovf_d = |(qsel >> N_BITS);
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         w_reg_q <= '0;
         sh_q    <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
         k_q     <= '0;
         sgn_q   <= 1'b0;
         n_q     <= '0;
         cor_q   <= 1'b0;
         unc_q   <= 1'b0;
         ovf_q   <= 1'b0;
         pos_q   <= '0;
      end else begin
         state_q <= state_d;
         w_reg_q <= w_reg_d;
         sh_q    <= sh_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         k_q     <= k_d;
         sgn_q   <= sgn_d;
         n_q     <= n_d;
         cor_q   <= cor_d;
         unc_q   <= unc_d;
         ovf_q   <= ovf_d;
         pos_q   <= pos_d;
      end
   end

   assign bus.in_ready      = state_q == IDLE;
   assign bus.out_valid     = state_q == DONE;
   assign bus.N             = n_q;
   assign bus.corrected     = cor_q;
   assign bus.uncorrectable = unc_q;
   assign bus.ovf           = ovf_q;
   assign bus.err_pos       = pos_q;
   assign bus.err_sign      = sgn_q;
endmodule

// File: tb/tb_an_sec_decoder_seq.sv
// Randomized and directed bench for an_sec_decoder_seq, two instances
// (K_RANGE=33 and K_RANGE=8), results compared to an arithmetic model.
module tb_an_sec_decoder_seq;
   localparam int A  = 67;
   localparam int WB = 32;
   localparam int NB = 25;

   typedef struct packed {
      logic [24:0] n;
      logic        cor;
      logic        unc;
      logic        ovf;
      logic [5:0]  pos;
      logic        sgn;
      logic [31:0] lat;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   an_sec_decoder_seq_if #(.W_BITS(32), .N_BITS(25), .P_BITS(6)) bus1 ();
   an_sec_decoder_seq_if #(.W_BITS(32), .N_BITS(25), .P_BITS(6)) bus2 ();

   an_sec_decoder_seq #(.A(67), .W_BITS(32), .A_BITS(7), .N_BITS(25), .K_RANGE(33), .P_BITS(6))
      dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
   an_sec_decoder_seq #(.A(67), .W_BITS(32), .A_BITS(7), .N_BITS(25), .K_RANGE(8), .P_BITS(6))
      dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

   // Reference: decode by plain modular arithmetic and latency formulas
   function automatic res_t model(input longint w, input int kr);
      res_t   r;
      longint rr, q, qs, p, e, wn;
      int     kf;
      bit     sg;
      r  = '0;
      rr = w % A;
      q  = w / A;
      qs = q;
      kf = -1;
      sg = 0;
      if (rr == 0) begin
         r.lat = WB + 1;
      end else begin
         for (int k = 0; k < kr; k++) begin
            p = (64'd1 << k) % A;
            if (rr == p) begin kf = k; sg = 0; break; end
            if (rr == A - p) begin kf = k; sg = 1; break; end
         end
         if (kf < 0) begin
            r.unc = 1;
            r.lat = WB + kr + 1;
         end else begin
            e     = sg ? -(64'd1 << kf) : (64'd1 << kf);
            wn    = w - e;
            r.sgn = sg;
            r.pos = 6'(kf);
            if (wn < 0 || wn >= (64'd1 << WB)) begin
               r.unc = 1;
               r.lat = WB + kf + 3;
            end else begin
               r.cor = 1;
               qs    = wn / A;
               r.lat = 2 * WB + kf + 3;
            end
         end
      end
      r.n   = qs[24:0];
      r.ovf = (qs >> NB) != 0;
      return r;
   endfunction

   function automatic res_t mk(input int n, input bit cor, input bit unc, input bit ovf,
                               input int pos, input bit sgn, input int lat);
      res_t r;
      r.n = 25'(n); r.cor = cor; r.unc = unc; r.ovf = ovf;
      r.pos = 6'(pos); r.sgn = sgn; r.lat = 32'(lat);
      return r;
   endfunction

   function automatic string fmt(input res_t r);
      return $sformatf("n=%0d cor=%0d unc=%0d ovf=%0d pos=%0d sgn=%0d lat=%0d",
                       r.n, r.cor, r.unc, r.ovf, r.pos, r.sgn, r.lat);
   endfunction

   // Drive one word into the selected instance and collect the result
   task automatic run_word(input bit sel, input logic [31:0] w, output res_t r, output bit to);
      int lat;
      bit ov;
      r  = '0;
      to = 0;
      @(negedge clk);
      if (sel) begin bus2.W = w; bus2.in_valid = 1'b1; end
      else     begin bus1.W = w; bus1.in_valid = 1'b1; end
      @(posedge clk);
      #1;
      bus1.in_valid = 1'b0;
      bus2.in_valid = 1'b0;
      lat = 1;
      while (lat < 400) begin
         @(negedge clk);
         ov = sel ? bus2.out_valid : bus1.out_valid;
         if (ov) break;
         lat++;
      end
      if (lat >= 400) to = 1;
      if (sel) r = '{n: bus2.N, cor: bus2.corrected, unc: bus2.uncorrectable, ovf: bus2.ovf,
                     pos: bus2.err_pos, sgn: bus2.err_sign, lat: 32'(lat)};
      else     r = '{n: bus1.N, cor: bus1.corrected, unc: bus1.uncorrectable, ovf: bus1.ovf,
                     pos: bus1.err_pos, sgn: bus1.err_sign, lat: 32'(lat)};
      if (sel) bus2.out_ready = 1'b1; else bus1.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus1.out_ready = 1'b0;
      bus2.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      tests++;
      if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0 || bus1.N !== '0 ||
          bus1.corrected !== 1'b0 || bus1.uncorrectable !== 1'b0 || bus1.ovf !== 1'b0 ||
          bus1.err_pos !== '0 || bus1.err_sign !== 1'b0 || bus2.in_ready !== 1'b1 ||
          bus2.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset: in_ready=%b out_valid=%b N=%0d cor=%b unc=%b ovf=%b pos=%0d sgn=%b, want 1 0 0 0 0 0 0 0",
                  bus1.in_ready, bus1.out_valid, bus1.N, bus1.corrected, bus1.uncorrectable,
                  bus1.ovf, bus1.err_pos, bus1.err_sign);
      end
      rst = 1'b0;
   endtask

   task automatic test_directed(input string name, input bit sel, input logic [31:0] w, input res_t want);
      res_t got, ref_r;
      bit   to;
      run_word(sel, w, got, to);
      ref_r = model(longint'(w), sel ? 8 : 33);
      tests++;
      if (to) begin
         fails++;
         $display("FAIL %s timeout: no out_valid within 400 cycles", name);
      end
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %s want %s", name, fmt(got), fmt(want));
      end
      tests++;
      if (got !== ref_r) begin
         fails++;
         $display("FAIL %s model: got %s want %s", name, fmt(got), fmt(ref_r));
      end
   endtask

   task automatic test_backpressure();
      res_t cap, now;
      int   lat;
      @(negedge clk);
      bus1.W = 32'd67256; bus1.in_valid = 1'b1;
      @(posedge clk); #1; bus1.in_valid = 1'b0;
      lat = 1;
      while (lat < 400) begin
         @(negedge clk);
         if (bus1.out_valid) break;
         lat++;
      end
      tests++;
      if (lat >= 400) begin
         fails++;
         $display("FAIL backpressure timeout: no out_valid within 400 cycles");
      end
      cap = '{n: bus1.N, cor: bus1.corrected, unc: bus1.uncorrectable, ovf: bus1.ovf,
              pos: bus1.err_pos, sgn: bus1.err_sign, lat: 32'(lat)};
      tests++;
      if (cap !== mk(1000, 1, 0, 0, 8, 0, 75)) begin
         fails++;
         $display("FAIL backpressure result: got %s want %s", fmt(cap), fmt(mk(1000, 1, 0, 0, 8, 0, 75)));
      end
      bus1.W = 32'd123; bus1.in_valid = 1'b1;   // must be ignored while DONE
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         now = '{n: bus1.N, cor: bus1.corrected, unc: bus1.uncorrectable, ovf: bus1.ovf,
                 pos: bus1.err_pos, sgn: bus1.err_sign, lat: 32'(lat)};
         tests++;
         if (now !== cap || bus1.out_valid !== 1'b1 || bus1.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL backpressure hold %0d: got %s ov=%b ir=%b want %s ov=1 ir=0",
                     i, fmt(now), bus1.out_valid, bus1.in_ready, fmt(cap));
         end
      end
      bus1.out_ready = 1'b1;
      @(posedge clk); #1;
      bus1.out_ready = 1'b0;
      bus1.in_valid  = 1'b0;
      @(negedge clk);
      tests++;
      if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL backpressure release: in_ready=%b out_valid=%b want 1 0", bus1.in_ready, bus1.out_valid);
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      @(negedge clk);
      bus1.W = 32'd67256; bus1.in_valid = 1'b1;
      @(posedge clk); #1; bus1.in_valid = 1'b0;
      repeat (50) @(negedge clk);      // inside DIV2 (periods 43..74)
      rst = 1'b1;
      @(negedge clk);
      tests++;
      if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid: in_ready=%b out_valid=%b want 1 0", bus1.in_ready, bus1.out_valid);
      end
      rst = 1'b0;
      seen = 0;
      repeat (60) begin
         @(negedge clk);
         if (bus1.out_valid) seen = 1;
      end
      tests++;
      if (seen) begin
         fails++;
         $display("FAIL reset_mid abandoned: out_valid=1 want 0");
      end
   endtask

   task automatic test_random();
      res_t   got, ref_r;
      bit     to, sel;
      int     mode, kk;
      longint n, wl;
      for (int i = 0; i < 40; i++) begin
         mode = $urandom_range(0, 3);
         sel  = 1'($urandom_range(0, 1));
         n    = longint'($urandom_range(0, 64103989));
         case (mode)
            0: wl = longint'($urandom);
            1: wl = A * n;
            2: begin
               kk = $urandom_range(0, 32);
               wl = $urandom_range(0, 1) ? A * n + (64'd1 << kk) : A * n - (64'd1 << kk);
               if (wl < 0 || wl >= (64'd1 << 32)) wl = A * n;
            end
            default: wl = longint'($urandom_range(0, 300));
         endcase
         run_word(sel, wl[31:0], got, to);
         ref_r = model(wl, sel ? 8 : 33);
         tests++;
         if (to || got !== ref_r) begin
            fails++;
            $display("FAIL random %0d (dut%0d W=%0d): got %s want %s", i, sel ? 2 : 1, wl, fmt(got), fmt(ref_r));
         end
      end
   endtask

   initial begin
      bus1.in_valid = 1'b0; bus1.out_ready = 1'b0; bus1.W = '0;
      bus2.in_valid = 1'b0; bus2.out_ready = 1'b0; bus2.W = '0;
      test_reset();
      test_directed("clean",    0, 32'd67000, mk(1000, 0, 0, 0, 0, 0, 33));
      test_directed("pos_err",  0, 32'd67256, mk(1000, 1, 0, 0, 8, 0, 75));
      test_directed("neg_err",  0, 32'd66992, mk(1000, 1, 0, 0, 3, 1, 70));
      test_directed("no_match", 1, 32'd67256, mk(1003, 0, 1, 0, 0, 0, 41));
      test_directed("check_oob", 0, 32'd61,   mk(0, 0, 1, 0, 7, 0, 42));
      test_directed("ovf_clean", 0, 32'd2248146944, mk(0, 0, 0, 1, 0, 0, 33));
      test_backpressure();
      test_reset_mid();
      test_directed("after_rst", 0, 32'd67000, mk(1000, 0, 0, 0, 0, 0, 33));
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
